// File: rtl/vme_pkg.sv
// Shared state encoding, slot limit and BAR constants for the VME BAR controller.
package vme_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSample,
        StCheck,
        StLocked,
        StError
    } state_e;

    localparam int unsigned MaxSlot  = 21;
    localparam int unsigned BarShift = 3;
    localparam int unsigned CntW     = 8;

    function automatic logic [7:0] slot_to_bar(input logic [4:0] s);
        return 8'(s) << BarShift;
    endfunction

    function automatic logic [7:0] bar_align(input logic [7:0] w);
        return (w >> BarShift) << BarShift;
    endfunction

    function automatic logic slot_in_range(input logic [4:0] s);
        return (s != 5'd0) && (32'(s) <= MaxSlot);
    endfunction

endpackage

// File: rtl/vme_ga_filter.sv
// GA pin debounce: holds the last sample and counts consecutive identical samples,
// strobing 'stable' on the sample that completes the run.
module vme_ga_filter
    import vme_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       run,
    input  logic [5:0] pins,
    output logic [5:0] sample,
    output logic       stable
);

    logic [5:0]      sample_q;
    logic [CntW-1:0] cnt_q;
    logic            match;

    assign match  = (pins == sample_q);
    assign stable = run && match && (cnt_q == CntW'(STABLE_CNT - 1));
    assign sample = sample_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= 6'h3F;
            cnt_q    <= '0;
        end else if (load) begin
            sample_q <= pins;
            cnt_q    <= '0;
        end else if (run) begin
            if (!match) begin
                sample_q <= pins;
                cnt_q    <= '0;
            end else if (stable) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/vme_bar_ctrl.sv
// VME geographic-address BAR controller: debounces GA, validates the slot and derives the
// CR/CSR base address. Define VME_GA_PARITY_EN to include the GAP pin in the check.
module vme_bar_ctrl
    import vme_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ga_n,
    input  logic       gap_n,
    input  logic       rescan,
    input  logic       bar_wr,
    input  logic [7:0] bar_wdata,
    output logic       bar_wr_ack,
    output logic [7:0] bar,
    output logic       bar_valid,
    output logic [4:0] slot,
    output logic       ga_err
);

    state_e     state_q;
    logic [5:0] pins;
    logic [5:0] sample;
    logic       stable;
    logic       load;
    logic       run;
    logic       parity_ok;
    logic       slot_ok;
    logic       wr_go;
    logic [4:0] cand_slot;

`ifdef VME_GA_PARITY_EN
    assign pins      = {gap_n, ga_n};
    assign parity_ok = ^sample;
`else
    // GAP bit is tied high so it can never cause a sample mismatch.
    logic unused_gap;
    assign pins       = {1'b1, ga_n};
    assign parity_ok  = 1'b1;
    assign unused_gap = ^{gap_n, sample[5]};
`endif

    assign load      = rescan || (state_q == StIdle);
    assign run       = !rescan && (state_q == StSample);
    assign cand_slot = ~sample[4:0];
    assign slot_ok   = slot_in_range(cand_slot) && parity_ok;
    // bar_wr is still high during the ack cycle; gating on the ack keeps it to one pulse.
    assign wr_go     = bar_wr && !bar_wr_ack && ((state_q == StLocked) || (state_q == StError));

    vme_ga_filter #(
        .STABLE_CNT(STABLE_CNT)
    ) u_filter (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .run   (run),
        .pins  (pins),
        .sample(sample),
        .stable(stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bar        <= '0;
            bar_valid  <= 1'b0;
            slot       <= '0;
            ga_err     <= 1'b0;
            bar_wr_ack <= 1'b0;
        end else begin
            bar_wr_ack <= 1'b0;
            if (rescan) begin
                state_q   <= StSample;
                bar       <= '0;
                bar_valid <= 1'b0;
                slot      <= '0;
                ga_err    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StSample;
                    end
                    StSample: begin
                        if (stable) begin
                            state_q <= StCheck;
                        end
                    end
                    StCheck: begin
                        if (slot_ok) begin
                            state_q   <= StLocked;
                            slot      <= cand_slot;
                            bar       <= slot_to_bar(cand_slot);
                            bar_valid <= 1'b1;
                            ga_err    <= 1'b0;
                        end else begin
                            state_q   <= StError;
                            slot      <= '0;
                            bar       <= '0;
                            bar_valid <= 1'b0;
                            ga_err    <= 1'b1;
                        end
                    end
                    StLocked, StError: begin
                        if (wr_go) begin
                            state_q    <= StLocked;
                            bar        <= bar_align(bar_wdata);
                            bar_valid  <= 1'b1;
                            ga_err     <= 1'b0;
                            bar_wr_ack <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vme_bar_ctrl.sv
// Scoreboard bench for vme_bar_ctrl: stimulus predicts every output change with its cycle,
// a negedge monitor pops and compares each change the DUT presents.
module tb_vme_bar_ctrl;

    localparam int unsigned STABLE_CNT = 16;

    typedef struct packed {
        logic [7:0] bar;
        logic       valid;
        logic [4:0] slot;
        logic       err;
        logic       ack;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ga_n;
    logic       gap_n;
    logic       rescan;
    logic       bar_wr;
    logic [7:0] bar_wdata;
    logic       bar_wr_ack;
    logic [7:0] bar;
    logic       bar_valid;
    logic [4:0] slot;
    logic       ga_err;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    obs_t exp_q[$];
    int   exp_cyc_q[$];
    obs_t model_out;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vme_bar_ctrl #(
        .STABLE_CNT(STABLE_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ga_n      (ga_n),
        .gap_n     (gap_n),
        .rescan    (rescan),
        .bar_wr    (bar_wr),
        .bar_wdata (bar_wdata),
        .bar_wr_ack(bar_wr_ack),
        .bar       (bar),
        .bar_valid (bar_valid),
        .slot      (slot),
        .ga_err    (ga_err)
    );

    function automatic obs_t mk(input logic [7:0] b, input logic v, input logic [4:0] s,
                                input logic e, input logic a);
        obs_t o;
        o.bar = b; o.valid = v; o.slot = s; o.err = e; o.ack = a;
        return o;
    endfunction

    function automatic bit parity_pass(input logic [4:0] g, input logic p);
`ifdef VME_GA_PARITY_EN
        return ($countones({p, g}) % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    // Outcome of an acquisition of a stable (g, p) pair, straight from the slot rules.
    function automatic obs_t acquire(input logic [4:0] g, input logic p);
        int s;
        s = 31 - int'(g);
        if (s >= 1 && s <= 21 && parity_pass(g, p))
            return mk(8'(s * 8), 1'b1, 5'(s), 1'b0, 1'b0);
        return mk(8'h00, 1'b0, 5'd0, 1'b1, 1'b0);
    endfunction

    task automatic expect_at(input obs_t o, input int e);
        if (o !== model_out) begin
            exp_q.push_back(o);
            exp_cyc_q.push_back(e);
        end
        model_out = o;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        obs_t cur;
        cur = {bar, bar_valid, slot, ga_err, bar_wr_ack};
        total++;
        if (cur !== '0) begin
            bad++;
            $display("FAIL %s got=%h required=0000", name, cur);
        end
    endtask

    // Rescan with new pins; returns the edge index at which the rescan is taken.
    task automatic do_rescan(input logic [4:0] g, input logic p, input bit lock, output int e);
        ga_n = g; gap_n = p; rescan = 1'b1; e = cyc + 1;
        expect_at('0, e);
        if (lock) expect_at(acquire(g, p), e + STABLE_CNT + 1);
        @(negedge clk);
        rescan = 1'b0;
    endtask

    // Write from LOCKED/ERROR; bar_wr is held through the ack cycle.
    task automatic do_write(input logic [7:0] wd);
        int   e;
        obs_t o;
        bar_wr = 1'b1; bar_wdata = wd; e = cyc + 1;
        o = mk(wd & 8'hF8, 1'b1, model_out.slot, 1'b0, 1'b1);
        expect_at(o, e);
        o.ack = 1'b0;
        expect_at(o, e + 1);
        @(negedge clk);
        @(negedge clk);
        bar_wr = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        obs_t cur;
        obs_t ex;
        int   ec;
        obs_t prev;
        bit   started;
        cur = {bar, bar_valid, slot, ga_err, bar_wr_ack};
        if (started && cur !== prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
            end else begin
                ex = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (cur !== ex || cyc != ec) begin
                    bad++;
                    $display("FAIL output_change cyc=%0d got=%h required=%h at cyc=%0d",
                             cyc, cur, ex, ec);
                end
            end
        end
        prev    = cur;
        started = mon_en;
    end

    initial begin : stim
        int e;
        int last;
        rst = 1'b1; ga_n = 5'h1E; gap_n = 1'b1; rescan = 1'b0;
        bar_wr = 1'b0; bar_wdata = 8'h00;
        model_out = '0;
        idle(3);
        check_zero("reset_state");
        mon_en = 1'b1;
        idle(1);

        // Stable from reset: bar_valid on edge STABLE_CNT+2 after release.
        rst = 1'b0; e = cyc + 1;
        expect_at(acquire(5'h1E, 1'b1), e + STABLE_CNT + 1);
        idle(25);

        do_rescan(5'h0A, 1'b1, 1'b1, e); idle(20);
        do_rescan(5'h09, 1'b1, 1'b1, e); idle(20);

        // Software write in ERROR.
        do_write(8'h5F); idle(3);

        // Write raised during SAMPLE is acked only once LOCKED.
        do_rescan(5'h1D, 1'b1, 1'b1, e);
        bar_wr = 1'b1; bar_wdata = 8'hC7;
        expect_at(mk(8'hC0, 1'b1, model_out.slot, 1'b0, 1'b1), e + STABLE_CNT + 2);
        expect_at(mk(8'hC0, 1'b1, model_out.slot, 1'b0, 1'b0), e + STABLE_CNT + 3);
        idle(STABLE_CNT + 2);
        bar_wr = 1'b0;
        idle(5);

        // Toggling pins never complete a stable run.
        do_rescan(5'h1E, 1'b1, 1'b0, e);
        last = e;
        for (int i = 0; i < 7; i++) begin
            idle(10);
            ga_n = (i % 2 == 0) ? 5'h1D : 5'h1E;
            last = cyc + 1;
        end
        expect_at(acquire(5'h1D, 1'b1), last + STABLE_CNT + 1);
        idle(22);

        // Even-parity pins: error with parity checking, slot 1 without.
        do_rescan(5'h1E, 1'b0, 1'b1, e); idle(20);

        // Rescan and write in the same cycle while LOCKED: rescan wins.
        do_rescan(5'h1D, 1'b1, 1'b1, e); idle(20);
        ga_n = 5'h1B; gap_n = 1'b1; rescan = 1'b1; bar_wr = 1'b1; bar_wdata = 8'hFF;
        e = cyc + 1;
        expect_at('0, e);
        expect_at(acquire(5'h1B, 1'b1), e + STABLE_CNT + 1);
        @(negedge clk);
        rescan = 1'b0; bar_wr = 1'b0;
        idle(20);

        // Reset mid-SAMPLE with a pending write discards both.
        do_rescan(5'h1C, 1'b0, 1'b0, e);
        bar_wr = 1'b1; bar_wdata = 8'hAA;
        idle(6);
        rst = 1'b1;
        idle(1);
        check_zero("rst_mid_sample");
        idle(2);
        bar_wr = 1'b0; rst = 1'b0; e = cyc + 1;
        expect_at(acquire(5'h1C, 1'b0), e + STABLE_CNT + 1);
        idle(22);

        // Reset while holding a result.
        rst = 1'b1; e = cyc + 1;
        expect_at('0, e);
        idle(3);
        check_zero("rst_locked");
        rst = 1'b0; e = cyc + 1;
        expect_at(acquire(ga_n, gap_n), e + STABLE_CNT + 1);
        idle(22);

        // Random pins with occasional software writes.
        for (int i = 0; i < 16; i++) begin
            do_rescan(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1, e);
            idle(STABLE_CNT + 2);
            if ($urandom_range(0, 1) == 1) do_write(8'($urandom_range(0, 255)));
            idle(2);
        end

        idle(5);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expect got=%0d outstanding required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vme_bar_ctrl.md
VME_BAR_CTRL -- requirements
Module: vme_bar_ctrl

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 16: consecutive identical GA samples required before the decode is accepted; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port ga_n, input, 5: raw active-low geographic address pins; slot = ~ga_n.
REQ-005 SHALL have port gap_n, input, 1: raw active-low GA parity pin.
REQ-006 SHALL have port rescan, input, 1: single-cycle pulse that restarts acquisition.
REQ-007 SHALL have port bar_wr, input, 1: software BAR write request, level, held until acked.
REQ-008 SHALL have port bar_wdata, input, 8: software BAR value; bits [2:0] ignored.
REQ-009 SHALL have port bar_wr_ack, output, 1: single-cycle acknowledge of bar_wr.
REQ-010 SHALL have port bar, output, 8: CR/CSR base address; bits [2:0] always 0.
REQ-011 SHALL have port bar_valid, output, 1: bar holds a usable value.
REQ-012 SHALL have port slot, output, 5: accepted slot number, 0 when none.
REQ-013 SHALL have port ga_err, output, 1: acquisition failed (range or parity).

Function
REQ-014 SHALL implement states IDLE, SAMPLE, CHECK, LOCKED, ERROR.
REQ-015 SHALL leave IDLE for SAMPLE on the first clock after rst deasserts, loading a sample register with {gap_n, ga_n} and clearing the stability counter.
REQ-016 SHALL, in SAMPLE, increment the counter when the current {gap_n, ga_n} equals the sample register; on any difference, reload the sample register and clear the counter.
REQ-017 SHALL go from SAMPLE to CHECK when the counter reaches STABLE_CNT-1 with a matching sample.
REQ-018 SHALL, in CHECK (one cycle), accept when ~ga_n is 1..21 and parity passes; accepting goes to LOCKED with slot=~ga_n, bar={~ga_n,3'b000}, bar_valid=1 and ga_err=0.
REQ-019 SHALL, in CHECK, reject slot 0 (ga_n=5'h1F), slots 22..31, or a parity failure; rejecting goes to ERROR with ga_err=1, bar=0, slot=0 and bar_valid=0.
REQ-020 SHALL ignore ga_n and gap_n changes while in LOCKED or ERROR; only rescan or rst re-acquires.
REQ-021 SHALL, when rescan is high in any state, go to SAMPLE next cycle with bar_valid=0, ga_err=0, slot=0, bar=0 and counter cleared.
REQ-022 SHALL, when bar_wr is high in LOCKED or ERROR, load bar={bar_wdata[7:3],3'b000}, set bar_valid=1, clear ga_err, enter LOCKED, leave slot unchanged, and pulse bar_wr_ack on the next cycle.
REQ-023 SHALL hold a bar_wr raised in IDLE, SAMPLE or CHECK pending, unacked, until LOCKED or ERROR is reached.
REQ-024 SHALL, when rescan and bar_wr coincide, let rescan win, with no write and no ack.
REQ-025 SHALL give bar_wr_ack at most one pulse per request; the requester must drop bar_wr the cycle after the ack.
REQ-026 SHALL, with inputs stable from reset, assert bar_valid on the (STABLE_CNT+2)th rising edge after rst deasserts.

Reset
REQ-027 SHALL, while rst is high, force state IDLE, counter=0, sample register=6'h3F, bar=0, bar_valid=0, slot=0, ga_err=0 and bar_wr_ack=0; a mid-acquisition or mid-write reset discards all progress and any pending write.

Configuration
REQ-028 SHALL compile the parity check under macro VME_GA_PARITY_EN: when defined, parity passes only if the six bits {gap_n, ga_n} have odd parity (an odd number of ones); when undefined, gap_n is excluded from the sample and compare and parity always passes.

Structure
REQ-029 SHALL place the state encoding, the 21-slot maximum and the BAR shift constant (3) in shared package vme_pkg.
REQ-030 SHALL contain one sub-module, vme_ga_filter (sample register, stability counter, stable strobe).

Verification
REQ-031 SHALL cover: ga_n=5'h1E, gap_n=1, stable from reset -> bar=8'h08, slot=1, bar_valid on edge 18 (STABLE_CNT=16).
REQ-032 SHALL cover: ga_n=5'h0A, gap_n=1 -> bar=8'hA8, slot=21; then ga_n=5'h09, gap_n=1, rescan pulse -> ga_err=1, bar=0.
REQ-033 SHALL cover: ga_n toggling 5'h1E/5'h1D every 10 cycles -> no CHECK entry, bar_valid stays 0; once held stable -> bar=8'h10 after STABLE_CNT+1 cycles.
REQ-034 SHALL cover, with VME_GA_PARITY_EN: ga_n=5'h1E, gap_n=0 -> ga_err=1; without the macro, the same input -> bar=8'h08.
REQ-035 SHALL cover: in ERROR, bar_wr with bar_wdata=8'h5F -> bar=8'h58, bar_valid=1, one-cycle ack; bar_wr during SAMPLE -> ack only after LOCKED.
REQ-036 SHALL cover: rescan and bar_wr in the same cycle in LOCKED -> no ack, bar_valid=0; rst asserted mid-SAMPLE -> all outputs 0.
